// File: rtl/axis_col_serializer.sv
// Column serializer: takes one wide COLS x ROWS result beat and streams it out
// one column (ROWS x Y_BITS) per handshake, honouring a per-beat active-column count.
module axis_col_serializer #(
   parameter int unsigned ROWS   = 8,
   parameter int unsigned COLS   = 24,
   parameter int unsigned Y_BITS = 32,
   parameter int unsigned CW     = $clog2(COLS + 1)
) (
   input  logic                        aclk,
   input  logic                        areset,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [COLS*ROWS*Y_BITS-1:0] s_data,
   input  logic [CW-1:0]               s_cols,
   input  logic                        s_last,
   input  logic                        s_last_pkt,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [ROWS*Y_BITS-1:0]      m_data,
   output logic                        m_last,
   output logic                        m_last_pkt
);
   localparam int unsigned SW = ROWS * Y_BITS;
   localparam int unsigned DW = COLS * SW;

   typedef enum logic {EMPTY = 1'b0, SHIFT = 1'b1} state_t;

   state_t        state, state_d;
   logic [DW-1:0] sreg, sreg_d;
   logic [CW-1:0] col, col_d;
   logic [CW-1:0] n_cols, n_cols_d;
   logic          tile_last, tile_last_d;
   logic          pkt_last, pkt_last_d;

   logic          final_col;
   logic          take;
   logic          accept;
   logic [CW-1:0] cols_clamped;

   // A new beat may enter while the last column of the current one is leaving.
   assign final_col    = (state == SHIFT) && (col == n_cols - CW'(1));
   assign take         = (state == SHIFT) && m_ready;
   assign s_ready      = !areset && ((state == EMPTY) || (take && final_col));
   assign accept       = s_valid && s_ready;
   assign cols_clamped = ((s_cols == '0) || (s_cols > CW'(COLS))) ? CW'(COLS) : s_cols;

   assign m_valid    = (state == SHIFT);
   assign m_data     = sreg[SW-1:0];
   assign m_last     = tile_last && final_col;
   assign m_last_pkt = pkt_last && final_col;

   // Next-state and datapath update; a capture overrides the drain to EMPTY.
   always_comb begin
      state_d     = state;
      sreg_d      = sreg;
      col_d       = col;
      n_cols_d    = n_cols;
      tile_last_d = tile_last;
      pkt_last_d  = pkt_last;

      if (take) begin
         if (final_col) begin
            state_d = EMPTY;
         end else begin
            sreg_d = sreg >> SW;
            col_d  = col + CW'(1);
         end
      end

      if (accept) begin
         state_d     = SHIFT;
         sreg_d      = s_data;
         col_d       = '0;
         n_cols_d    = cols_clamped;
         tile_last_d = s_last || s_last_pkt;
         pkt_last_d  = s_last_pkt;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state     <= EMPTY;
         sreg      <= '0;
         col       <= '0;
         n_cols    <= '0;
         tile_last <= 1'b0;
         pkt_last  <= 1'b0;
      end else begin
         state     <= state_d;
         sreg      <= sreg_d;
         col       <= col_d;
         n_cols    <= n_cols_d;
         tile_last <= tile_last_d;
         pkt_last  <= pkt_last_d;
      end
   end

endmodule

// File: tb/tb_axis_col_serializer.sv
// Self-checking bench for axis_col_serializer: a queue-of-columns reference model
// predicts every output column, s_ready and the last flags cycle by cycle.
module tb_axis_col_serializer;
   localparam int unsigned ROWS   = 2;
   localparam int unsigned COLS   = 4;
   localparam int unsigned Y_BITS = 8;
   localparam int unsigned CW     = 3;
   localparam int unsigned SW     = ROWS * Y_BITS;
   localparam int unsigned DW     = COLS * SW;

   typedef struct packed {
      logic [SW-1:0] data;
      logic          last;
      logic          last_pkt;
   } col_t;

   logic          aclk = 1'b0;
   logic          areset = 1'b1;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] s_data = '0;
   logic [CW-1:0] s_cols = '0;
   logic          s_last = 1'b0;
   logic          s_last_pkt = 1'b0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [SW-1:0] m_data;
   logic          m_last;
   logic          m_last_pkt;

   col_t model_q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   logic          obs_valid, obs_sready, obs_last, obs_last_pkt;
   logic [SW-1:0] obs_data;
   logic          exp_valid, exp_sready, exp_last, exp_last_pkt;
   logic [SW-1:0] exp_data;
   logic          hs_out, hs_in;

   axis_col_serializer #(.ROWS(ROWS), .COLS(COLS), .Y_BITS(Y_BITS), .CW(CW)) dut (
      .aclk(aclk), .areset(areset),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_cols(s_cols),
      .s_last(s_last), .s_last_pkt(s_last_pkt),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_last(m_last), .m_last_pkt(m_last_pkt)
   );

   always #5 aclk = ~aclk;

   // One clock: drive at negedge, sample just after, predict, then advance the model past the posedge.
   task automatic cycle(input logic rst, input logic sv, input logic [DW-1:0] d, input int c,
                        input logic l, input logic lp, input logic mr);
      int   n;
      col_t e;
      @(negedge aclk);
      areset = rst; s_valid = sv; s_data = d; s_cols = CW'(c);
      s_last = l; s_last_pkt = lp; m_ready = mr;
      #1;
      obs_valid = m_valid; obs_sready = s_ready; obs_data = m_data;
      obs_last = m_last; obs_last_pkt = m_last_pkt;
      exp_valid    = (model_q.size() != 0);
      exp_data     = exp_valid ? model_q[0].data : '0;
      exp_last     = exp_valid && model_q[0].last;
      exp_last_pkt = exp_valid && model_q[0].last_pkt;
      exp_sready   = !rst && ((model_q.size() == 0) || (mr && model_q.size() == 1));
      hs_out = !rst && exp_valid && mr;
      hs_in  = sv && exp_sready;
      if (rst) begin
         model_q.delete();
      end else begin
         if (hs_out) void'(model_q.pop_front());
         if (hs_in) begin
            n = ((c == 0) || (c > int'(COLS))) ? int'(COLS) : c;
            for (int i = 0; i < n; i++) begin
               e.data     = d[i*SW +: SW];
               e.last     = (l || lp) && (i == n - 1);
               e.last_pkt = lp && (i == n - 1);
               model_q.push_back(e);
            end
         end
      end
      @(posedge aclk);
   endtask

   task automatic test_reset();
      cycle(1'b1, 1'b0, '0, 0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, '0, 0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, '0, 0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if ({obs_valid, obs_sready, obs_last, obs_last_pkt} !== 4'b0000 || obs_data !== '0) begin
         n_fail++;
         $display("FAIL reset_held: valid/ready/last/pkt got %b%b%b%b data %h, want 0000 data 0",
                  obs_valid, obs_sready, obs_last, obs_last_pkt, obs_data);
      end
      cycle(1'b0, 1'b0, '0, 0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if ({obs_valid, obs_sready, obs_last, obs_last_pkt} !== 4'b0100 || obs_data !== '0) begin
         n_fail++;
         $display("FAIL reset_release: valid/ready/last/pkt got %b%b%b%b data %h, want 0100 data 0",
                  obs_valid, obs_sready, obs_last, obs_last_pkt, obs_data);
      end
   endtask

   // Single beat with full or narrowed column count; checks model per cycle and the literal column values.
   task automatic test_single(input string name, input int c, input logic l, input logic lp,
                              input int n_exp);
      logic [DW-1:0] beat;
      logic [SW-1:0] want [4];
      logic [SW-1:0] got [$];
      int            first;
      logic          ready_on_last;
      beat = 64'h0807_0605_0403_0201;
      want = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};
      first = -1;
      ready_on_last = 1'b0;
      for (int k = 0; k < 7; k++) begin
         cycle(1'b0, (k == 0), beat, c, l, lp, 1'b1);
         n_checks++;
         if (obs_valid !== exp_valid || obs_sready !== exp_sready || obs_last !== exp_last ||
             obs_last_pkt !== exp_last_pkt || (exp_valid && obs_data !== exp_data)) begin
            n_fail++;
            $display("FAIL %s cyc%0d: v/r/l/p got %b%b%b%b %h want %b%b%b%b %h", name, k,
                     obs_valid, obs_sready, obs_last, obs_last_pkt, obs_data,
                     exp_valid, exp_sready, exp_last, exp_last_pkt, exp_data);
         end
         if (obs_valid === 1'b1) begin
            if (first < 0) first = k;
            got.push_back(obs_data);
            if (obs_last === 1'b1) ready_on_last = obs_sready;
         end
      end
      n_checks++;
      if (first != 1 || got.size() != n_exp) begin
         n_fail++;
         $display("FAIL %s_count: first output cycle %0d, columns %0d, want 1 and %0d",
                  name, first, got.size(), n_exp);
      end else begin
         for (int i = 0; i < n_exp; i++) begin
            n_checks++;
            if (got[i] !== want[i]) begin
               n_fail++;
               $display("FAIL %s_col%0d: got %h want %h", name, i, got[i], want[i]);
            end
         end
      end
      n_checks++;
      if (ready_on_last !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_ready_on_final: s_ready got %b want 1", name, ready_on_last);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] beats [3];
      int idx, n_valid, first, last_v, n_pulse;
      int pulses [3];
      for (int i = 0; i < 3; i++) beats[i] = {$urandom(), $urandom()};
      idx = 0; n_valid = 0; first = -1; last_v = -1; n_pulse = 0;
      for (int k = 0; k < 20; k++) begin
         cycle(1'b0, (idx < 3), (idx < 3) ? beats[idx] : '0, 0, 1'b1, 1'b0, 1'b1);
         if (hs_in) idx++;
         n_checks++;
         if (obs_valid !== exp_valid || obs_sready !== exp_sready || obs_last !== exp_last ||
             obs_last_pkt !== exp_last_pkt || (exp_valid && obs_data !== exp_data)) begin
            n_fail++;
            $display("FAIL b2b cyc%0d: v/r/l/p got %b%b%b%b %h want %b%b%b%b %h", k,
                     obs_valid, obs_sready, obs_last, obs_last_pkt, obs_data,
                     exp_valid, exp_sready, exp_last, exp_last_pkt, exp_data);
         end
         if (obs_valid === 1'b1) begin
            if (first < 0) first = k;
            last_v = k;
            n_valid++;
            if (obs_sready === 1'b1 && n_pulse < 3) begin
               pulses[n_pulse] = k - first + 1;
               n_pulse++;
            end
         end
      end
      n_checks++;
      if (n_valid != 12 || (last_v - first + 1) != 12) begin
         n_fail++;
         $display("FAIL b2b_contiguous: valid cycles %0d span %0d, want 12 and 12",
                  n_valid, last_v - first + 1);
      end
      n_checks++;
      if (n_pulse != 3 || pulses[0] != 4 || pulses[1] != 8 || pulses[2] != 12) begin
         n_fail++;
         $display("FAIL b2b_ready_pulses: count %0d at %0d,%0d,%0d want 3 at 4,8,12",
                  n_pulse, pulses[0], pulses[1], pulses[2]);
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] rd;
      int            rc, beats, cyc;
      logic          rl, rlp, pending, mr, prev_hold;
      logic [SW-1:0] prev_data;
      beats = 0; cyc = 0; pending = 1'b0; prev_hold = 1'b0; prev_data = '0;
      rd = '0; rc = 0; rl = 1'b0; rlp = 1'b0;
      while ((beats < 200 || model_q.size() != 0) && cyc < 20000) begin
         if (!pending && beats < 200 && $urandom_range(0, 3) != 0) begin
            rd = {$urandom(), $urandom()};
            rc = $urandom_range(0, 7);
            rl = 1'($urandom_range(0, 1));
            rlp = ($urandom_range(0, 3) == 0);
            pending = 1'b1;
         end
         mr = 1'($urandom_range(0, 1));
         cycle(1'b0, pending, rd, rc, rl, rlp, mr);
         if (hs_in) begin
            pending = 1'b0;
            beats++;
         end
         n_checks++;
         if (obs_valid !== exp_valid || obs_sready !== exp_sready || obs_last !== exp_last ||
             obs_last_pkt !== exp_last_pkt || (exp_valid && obs_data !== exp_data)) begin
            n_fail++;
            $display("FAIL random cyc%0d: v/r/l/p got %b%b%b%b %h want %b%b%b%b %h", cyc,
                     obs_valid, obs_sready, obs_last, obs_last_pkt, obs_data,
                     exp_valid, exp_sready, exp_last, exp_last_pkt, exp_data);
         end
         if (prev_hold) begin
            n_checks++;
            if (obs_valid !== 1'b1 || obs_data !== prev_data) begin
               n_fail++;
               $display("FAIL random_stall_stable cyc%0d: valid %b data %h want 1 %h",
                        cyc, obs_valid, obs_data, prev_data);
            end
         end
         prev_hold = (obs_valid === 1'b1) && !mr;
         prev_data = obs_data;
         cyc++;
      end
      n_checks++;
      if (beats != 200 || model_q.size() != 0) begin
         n_fail++;
         $display("FAIL random_drain: beats %0d pending cols %0d, want 200 and 0",
                  beats, model_q.size());
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] b1, b2;
      logic          saw_last;
      logic [SW-1:0] first_data;
      int            n_out;
      b1 = {$urandom(), $urandom()};
      b2 = {$urandom(), $urandom()};
      cycle(1'b0, 1'b1, b1, 0, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, '0, 0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, '0, 0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, '0, 0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (obs_valid !== 1'b1 || obs_data !== b1[2*SW +: SW] || obs_last !== 1'b0 || obs_sready !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_col2: valid %b data %h last %b ready %b want 1 %h 0 0",
                  obs_valid, obs_data, obs_last, obs_sready, b1[2*SW +: SW]);
      end
      cycle(1'b1, 1'b0, '0, 0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (obs_valid !== 1'b0 || obs_sready !== 1'b0 || obs_last !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_held: valid %b ready %b last %b want 0 0 0",
                  obs_valid, obs_sready, obs_last);
      end
      saw_last = 1'b0; first_data = '0; n_out = 0;
      for (int k = 0; k < 7; k++) begin
         cycle(1'b0, (k == 0), b2, 0, 1'b1, 1'b0, 1'b1);
         n_checks++;
         if (obs_valid !== exp_valid || obs_sready !== exp_sready || obs_last !== exp_last ||
             obs_last_pkt !== exp_last_pkt || (exp_valid && obs_data !== exp_data)) begin
            n_fail++;
            $display("FAIL rstmid_after cyc%0d: v/r/l/p got %b%b%b%b %h want %b%b%b%b %h", k,
                     obs_valid, obs_sready, obs_last, obs_last_pkt, obs_data,
                     exp_valid, exp_sready, exp_last, exp_last_pkt, exp_data);
         end
         if (obs_valid === 1'b1) begin
            if (n_out == 0) first_data = obs_data;
            if (obs_last === 1'b1) saw_last = (n_out == 3);
            n_out++;
         end
      end
      n_checks++;
      if (first_data !== b2[SW-1:0] || !saw_last || n_out != 4) begin
         n_fail++;
         $display("FAIL rstmid_restart: first %h cols %0d last_ok %b want %h 4 1",
                  first_data, n_out, saw_last, b2[SW-1:0]);
      end
   endtask

   initial begin
      test_reset();
      test_single("basic", 0, 1'b1, 1'b0, 4);
      test_single("narrow", 2, 1'b0, 1'b1, 2);
      test_single("clamp", 7, 1'b1, 1'b1, 4);
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
